// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous RAM, with an
// optional post-reset sweep that writes a fixed value to every word.
module ram_port_arbiter #(
  parameter int                ADDR_W    = 13,
  parameter int                DATA_W    = 2,
  parameter bit                CLEAR_EN  = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_i,
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [DATA_W-1:0] di0_i,
  input  logic              req1_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] di1_i,
  output logic              ack0_o,
  output logic              ack1_o,
  output logic [DATA_W-1:0] do0_o,
  output logic [DATA_W-1:0] do1_o,
  output logic              dv0_o,
  output logic              dv1_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_di_o,
  input  logic [DATA_W-1:0] ram_do_i,
  output logic              busy_o
);

  typedef enum logic {
    ST_CLEAR,
    ST_SERVE
  } state_e;

  localparam state_e            RST_STATE = CLEAR_EN ? ST_CLEAR : ST_SERVE;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                pri_q, pri_d;   // 0: requester 0 wins a tie, 1: requester 1
  logic                dv0_q, dv0_d;
  logic                dv1_q, dv1_d;
  logic                grant0, grant1;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      pri_q   <= 1'b0;
      dv0_q   <= 1'b0;
      dv1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pri_q   <= pri_d;
      dv0_q   <= dv0_d;
      dv1_q   <= dv1_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case/if tree can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pri_d      = pri_q;
    grant0     = 1'b0;
    grant1     = 1'b0;
    ram_en_o   = 1'b0;
    ram_we_o   = 1'b0;
    ram_addr_o = '0;
    ram_di_o   = '0;
    busy_o     = 1'b0;

    // Reset is synchronous for the state, but the port is quiet immediately.
    if (!rst_i) begin
      case (state_q)
        ST_CLEAR: begin
          busy_o     = 1'b1;
          ram_en_o   = 1'b1;
          ram_we_o   = 1'b1;
          ram_addr_o = cnt_q;
          ram_di_o   = CLEAR_VAL;
          if (cnt_q == LAST_ADDR) begin
            state_d = ST_SERVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_SERVE: begin
          grant0 = req0_i & (~req1_i | ~pri_q);
          grant1 = req1_i & ~grant0;
          if (grant0) begin
            ram_en_o   = 1'b1;
            ram_we_o   = we0_i;
            ram_addr_o = addr0_i;
            ram_di_o   = di0_i;
            pri_d      = 1'b1;
          end else if (grant1) begin
            ram_en_o   = 1'b1;
            ram_we_o   = we1_i;
            ram_addr_o = addr1_i;
            ram_di_o   = di1_i;
            pri_d      = 1'b0;
          end
        end

        default: state_d = RST_STATE;
      endcase
    end
  end

  // Read data returns one cycle after the grant; tag it with its owner.
  assign dv0_d  = grant0 & ~we0_i;
  assign dv1_d  = grant1 & ~we1_i;

  assign ack0_o = grant0;
  assign ack1_o = grant1;
  assign dv0_o  = dv0_q & ~rst_i;
  assign dv1_o  = dv1_q & ~rst_i;
  assign do0_o  = ram_do_i;
  assign do1_o  = ram_do_i;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench: instance A sweeps (CLEAR_VAL=2'b10) against a RAM model,
// instance B has no sweep and exercises immediate service and contention.
module tb_ram_port_arbiter;

  localparam int AW    = 13;
  localparam int DW    = 2;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          a_rst, a_req0, a_req1, a_we0, a_we1;
  logic [AW-1:0] a_addr0, a_addr1, a_ram_addr;
  logic [DW-1:0] a_di0, a_di1, a_do0, a_do1, a_ram_di, a_ram_do;
  logic          a_ack0, a_ack1, a_dv0, a_dv1, a_en, a_we, a_busy;

  logic          b_rst, b_req0, b_req1, b_we0, b_we1;
  logic [AW-1:0] b_addr0, b_addr1, b_ram_addr;
  logic [DW-1:0] b_di0, b_di1, b_do0, b_do1, b_ram_di, b_ram_do;
  logic          b_ack0, b_ack1, b_dv0, b_dv1, b_en, b_we, b_busy;

  assign b_ram_do = '0;

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CLEAR_EN(1'b1), .CLEAR_VAL(2'b10)) u_a (
    .clk_i(clk), .rst_i(a_rst),
    .req0_i(a_req0), .we0_i(a_we0), .addr0_i(a_addr0), .di0_i(a_di0),
    .req1_i(a_req1), .we1_i(a_we1), .addr1_i(a_addr1), .di1_i(a_di1),
    .ack0_o(a_ack0), .ack1_o(a_ack1), .do0_o(a_do0), .do1_o(a_do1),
    .dv0_o(a_dv0), .dv1_o(a_dv1), .ram_en_o(a_en), .ram_we_o(a_we),
    .ram_addr_o(a_ram_addr), .ram_di_o(a_ram_di), .ram_do_i(a_ram_do),
    .busy_o(a_busy)
  );

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CLEAR_EN(1'b0), .CLEAR_VAL(2'b10)) u_b (
    .clk_i(clk), .rst_i(b_rst),
    .req0_i(b_req0), .we0_i(b_we0), .addr0_i(b_addr0), .di0_i(b_di0),
    .req1_i(b_req1), .we1_i(b_we1), .addr1_i(b_addr1), .di1_i(b_di1),
    .ack0_o(b_ack0), .ack1_o(b_ack1), .do0_o(b_do0), .do1_o(b_do1),
    .dv0_o(b_dv0), .dv1_o(b_dv1), .ram_en_o(b_en), .ram_we_o(b_we),
    .ram_addr_o(b_ram_addr), .ram_di_o(b_ram_di), .ram_do_i(b_ram_do),
    .busy_o(b_busy)
  );

  // Synchronous single-port RAM behind instance A.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (a_en) begin
      if (a_we) mem[a_ram_addr] <= a_ram_di;
      else      a_ram_do <= mem[a_ram_addr];
    end
  end

  int wr_cnt [DEPTH];
  logic b_busy_seen = 1'b0;
  always @(negedge clk) if (b_busy === 1'b1) b_busy_seen <= 1'b1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Follows A's sweep from the current cycle; stops when BUSY drops or after
  // stop_at cycles (stop_at < 0: no limit). Returns at a negedge.
  task automatic sweep(input string tag, input int stop_at, output int n);
    int addr_err = 0;
    int ack_err  = 0;
    n = 0;
    for (int i = 0; i < DEPTH + 16; i++) begin
      @(negedge clk);
      if (a_busy !== 1'b1 || n == stop_at) break;
      if (a_en !== 1'b1 || a_we !== 1'b1 || a_ram_addr !== AW'(n) || a_ram_di !== 2'b10)
        addr_err++;
      if (a_ack0 !== 1'b0 || a_ack1 !== 1'b0) ack_err++;
      wr_cnt[a_ram_addr]++;
      n++;
      tick();
    end
    check({tag, "_addr_err"}, addr_err, 0);
    check({tag, "_ack_err"}, ack_err, 0);
  endtask

  task automatic check_once(input string tag);
    int errs = 0;
    for (int i = 0; i < DEPTH; i++) if (wr_cnt[i] != 1) errs++;
    check(tag, errs, 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < DEPTH; i++) wr_cnt[i] = 0;
    a_rst = 1'b1; a_req0 = 1'b1; a_req1 = 1'b1; a_we0 = 1'b0; a_we1 = 1'b0;
    a_addr0 = '0; a_addr1 = '0; a_di0 = '0; a_di1 = '0;
    b_rst = 1'b1; b_req0 = 1'b1; b_req1 = 1'b1; b_we0 = 1'b0; b_we1 = 1'b0;
    b_addr0 = '0; b_addr1 = '0; b_di0 = '0; b_di1 = '0;

    // Reset: requests held, nothing may be acknowledged or enabled.
    repeat (3) tick();
    @(negedge clk);
    check("rst_ack", {a_ack0, a_ack1, b_ack0, b_ack1}, 0);
    check("rst_ram", {a_en, a_we, b_en, b_we}, 0);
    check("rst_busy", {a_busy, b_busy}, 0);
    check("rst_dv", {a_dv0, a_dv1, b_dv0, b_dv1}, 0);

    // Sweep with requester 0 waiting to read 0x1A5.
    tick();
    a_rst = 1'b0; a_req1 = 1'b0; a_addr0 = AW'(13'h1A5);
    b_req0 = 1'b0; b_req1 = 1'b0;
    sweep("sweep1", -1, n);
    check("sweep1_len", n, DEPTH);
    check_once("sweep1_once");
    check("post_sweep_ack0", {a_ack0, a_ack1}, 2'b10);
    check("post_sweep_addr", a_ram_addr, 13'h1A5);
    check("post_sweep_we", a_we, 1'b0);
    tick();
    a_req0 = 1'b0;
    @(negedge clk);
    check("rd1a5_dv", {a_dv0, a_dv1}, 2'b10);
    check("rd1a5_do", a_do0, 2'b10);

    // Requester 0: write 2'b01 to 0x40 then read it back.
    tick();
    a_req0 = 1'b1; a_we0 = 1'b1; a_addr0 = 13'h040; a_di0 = 2'b01;
    @(negedge clk);
    check("wr40_ack", {a_ack0, a_ack1}, 2'b10);
    check("wr40_port", {a_en, a_we, a_ram_addr, a_ram_di}, {2'b11, 13'h040, 2'b01});
    tick();
    a_we0 = 1'b0;
    @(negedge clk);
    check("rd40_ack", {a_ack0, a_ack1}, 2'b10);
    check("rd40_we", {a_en, a_we}, 2'b10);
    check("wr40_no_dv", {a_dv0, a_dv1}, 2'b00);
    tick();
    a_req0 = 1'b0;
    @(negedge clk);
    check("rd40_dv", {a_dv0, a_dv1}, 2'b10);
    check("rd40_do", a_do0, 2'b01);
    check("idle_en", {a_en, a_we, a_ack0, a_ack1}, 0);
    tick();
    @(negedge clk);
    check("rd40_dv_once", a_dv0, 1'b0);

    // Preload 0x10/0x11 with both requesting; last grant was 0, so 1 wins.
    tick();
    a_req0 = 1'b1; a_we0 = 1'b1; a_addr0 = 13'h010; a_di0 = 2'b11;
    a_req1 = 1'b1; a_we1 = 1'b1; a_addr1 = 13'h011; a_di1 = 2'b00;
    @(negedge clk);
    check("pre_ack_1st", {a_ack0, a_ack1}, 2'b01);
    tick();
    a_req1 = 1'b0;
    @(negedge clk);
    check("pre_ack_2nd", {a_ack0, a_ack1}, 2'b10);

    // Back-to-back reads to alternating requesters.
    tick();
    a_we0 = 1'b0;
    @(negedge clk);
    check("b2b_ack0", {a_ack0, a_ack1}, 2'b10);
    tick();
    a_req0 = 1'b0; a_req1 = 1'b1; a_we1 = 1'b0;
    @(negedge clk);
    check("b2b_ack1", {a_ack0, a_ack1}, 2'b01);
    check("b2b_dv0", {a_dv0, a_dv1}, 2'b10);
    check("b2b_do0", a_do0, 2'b11);
    tick();
    a_req1 = 1'b0;
    @(negedge clk);
    check("b2b_dv1", {a_dv0, a_dv1}, 2'b01);
    check("b2b_do1", a_do1, 2'b00);

    // Read granted, then reset in the following cycle: DV must be dropped.
    tick();
    a_req0 = 1'b1; a_addr0 = 13'h040;
    @(negedge clk);
    check("pre_rst_ack", a_ack0, 1'b1);
    tick();
    a_req0 = 1'b0; a_req1 = 1'b1; a_rst = 1'b1;
    @(negedge clk);
    check("rst_dv_drop", {a_dv0, a_dv1}, 0);
    check("rst_quiet", {a_ack0, a_ack1, a_en, a_busy}, 0);
    tick();
    a_rst = 1'b0; a_req1 = 1'b0;

    // Reset at clear count 100, then a full sweep from address 0.
    sweep("sweep2", 100, n);
    check("sweep2_len", n, 100);
    a_rst = 1'b1;
    #1;
    check("mid_rst_quiet", {a_ack0, a_ack1, a_dv0, a_dv1, a_en, a_busy}, 0);
    tick();
    a_rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) wr_cnt[i] = 0;
    sweep("sweep3", -1, n);
    check("sweep3_len", n, DEPTH);
    check_once("sweep3_once");

    // Instance B: no sweep, immediate service after release.
    tick();
    b_rst = 1'b0; b_req1 = 1'b1; b_addr1 = 13'h005;
    @(negedge clk);
    check("b_first_ack", {b_ack0, b_ack1}, 2'b01);
    check("b_first_en", {b_en, b_busy}, 2'b10);
    tick();
    b_req1 = 1'b0;
    @(negedge clk);
    check("b_first_dv", {b_dv0, b_dv1}, 2'b01);

    // Contention just after reset: grants 0,1,0,1.
    tick();
    b_rst = 1'b1;
    tick();
    b_rst = 1'b0; b_req0 = 1'b1; b_req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("cont_ack%0d", i), {b_ack0, b_ack1}, (i % 2 == 0) ? 2'b10 : 2'b01);
      tick();
    end
    b_req0 = 1'b0; b_req1 = 1'b0;
    @(negedge clk);
    check("b_busy_never", b_busy_seen, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 13: RAM port address width.
REQ-002 Parameter DATA_W, default 2: RAM port data width.
REQ-003 Parameter CLEAR_EN, default 1: 1 = run a memory clear sweep after reset; 0 = skip the sweep.
REQ-004 Parameter CLEAR_VAL, default 0 (DATA_W bits): value written to every word during the clear sweep.
REQ-005 CLK  in  1  single clock; all logic on rising edge.
REQ-006 RST  in  1  reset, synchronous, active-high.
REQ-007 REQ0/REQ1  in  1  access request from requester 0/1; held until the matching ACK.
REQ-008 WE0/WE1  in  1  1 = write, 0 = read; held with REQ.
REQ-009 ADDR0/ADDR1  in  ADDR_W  access address; held with REQ.
REQ-010 DI0/DI1  in  DATA_W  write data; held with REQ.
REQ-011 ACK0/ACK1  out  1  combinational; high in the cycle the access is issued to the RAM.
REQ-012 DO0/DO1  out  DATA_W  read data; equals RAM_DO.
REQ-013 DV0/DV1  out  1  registered; read data valid on DOx.
REQ-014 RAM_EN, RAM_WE  out  1  RAM port enable and write enable.
REQ-015 RAM_ADDR  out  ADDR_W; RAM_DI  out  DATA_W  RAM port address and write data.
REQ-016 RAM_DO  in  DATA_W  RAM read data, valid one cycle after an enabled read.
REQ-017 BUSY  out  1  high while the clear sweep is running.

Function
REQ-018 The block SHALL have two states: CLEAR and SERVE.
REQ-019 In CLEAR, the block SHALL drive RAM_EN=1, RAM_WE=1, RAM_ADDR=clear counter and RAM_DI=CLEAR_VAL, with BUSY=1 and ACK0=ACK1=0.
REQ-020 The clear counter SHALL start at 0 and increment by 1 each cycle.
REQ-021 In the cycle the clear counter equals 2^ADDR_W-1, that last write SHALL be issued and the state SHALL become SERVE on the next edge; the counter SHALL NOT wrap and write address 0 again.
REQ-022 In SERVE with no REQ, RAM_EN SHALL be 0, RAM_WE SHALL be 0 and both ACKs SHALL be 0.
REQ-023 In SERVE with exactly one REQx high, that requester SHALL be granted in the same cycle.
REQ-024 In SERVE with both REQs high, the requester indicated by the priority pointer PRI SHALL be granted.
REQ-025 On a grant, the block SHALL drive ACKx=1, RAM_EN=1, RAM_WE=WEx, RAM_ADDR=ADDRx and RAM_DI=DIx; at most one ACK SHALL be high per cycle.
REQ-026 After any grant to requester x, PRI SHALL point to the other requester; PRI SHALL be unchanged in cycles with no grant.
REQ-027 A requester that holds REQ high SHALL be granted within 2 cycles (no starvation).
REQ-028 A read granted in cycle t SHALL give DVx=1 in cycle t+1 only, with DOx=RAM_DO; a write SHALL never assert DV.
REQ-029 A requester MAY present its next request in the cycle after its ACK, giving back-to-back accesses at one per cycle. Reads in consecutive cycles to alternating requesters SHALL each raise DV for the correct requester only.
REQ-030 DO0/DO1 SHALL be qualified only by DV; their value while DV=0 is unspecified.
REQ-031 REQ seen in CLEAR SHALL NOT be acknowledged until SERVE is entered.

Reset
REQ-032 While RST=1, the block SHALL hold ACK0=ACK1=0, DV0=DV1=0, RAM_EN=0, RAM_WE=0 and PRI=0.
REQ-033 While RST=1, BUSY SHALL be 0 and the clear counter SHALL be held at 0.
REQ-034 On the first edge with RST=0, the state SHALL be CLEAR if CLEAR_EN=1, otherwise SERVE.
REQ-035 RST asserted during CLEAR or SERVE SHALL take effect on the next edge and abort the operation in progress. Any pending DV SHALL be dropped, and the clear sweep SHALL restart from address 0 after release.

Verification
REQ-036 Clear sweep: CLEAR_EN=1, CLEAR_VAL=2'b10, release RST -> BUSY high for exactly 8192 cycles; addresses 0..8191 written once each; read of 0x1A5 afterwards returns 2'b10.
REQ-037 Single-requester write then read: REQ0 writes 2'b01 to 0x0040, then reads 0x0040 -> ACK0 in each request cycle; DV0=1 one cycle after the read ACK with DO0=2'b01; DV1 stays 0.
REQ-038 Contention: REQ0 and REQ1 both held for 4 cycles just after reset -> grants in order 0,1,0,1 with exactly one ACK per cycle.
REQ-039 Back-to-back reads to alternating requesters (0 reads 0x10, 1 reads 0x11, preloaded 2'b11 and 2'b00) -> DV0 with 2'b11, then DV1 with 2'b00, in consecutive cycles.
REQ-040 Reset mid-sweep: assert RST at clear count 100 for 1 cycle -> ACKs, DVs and RAM_EN are 0; the sweep restarts at address 0 and BUSY lasts a full 8192 cycles.
REQ-041 CLEAR_EN=0: request from REQ1 in the first cycle after reset release -> ACK1 in that cycle; BUSY never asserts.
